// File: rtl/crt_timing_if.sv
// Raster signal bundle between the CRT timing controller and its neighbours.
//   master : the timing controller. It takes PixelClock and drives the sync,
//            visibility, coordinate and strobe outputs.
//   slave  : the divider/drawing side. It drives PixelClock and consumes the
//            raster outputs.
interface crt_timing_if;
  logic       PixelClock;
  logic       HSync;
  logic       VSync;
  logic       VideoOn;
  logic [9:0] PixelX;
  logic [9:0] PixelY;
  logic       LineStart;
  logic       FrameStart;

  modport master (
    input  PixelClock,
    output HSync, VSync, VideoOn, PixelX, PixelY, LineStart, FrameStart
  );

  modport slave (
    output PixelClock,
    input  HSync, VSync, VideoOn, PixelX, PixelY, LineStart, FrameStart
  );
endinterface

// File: rtl/crt_timing_controller.sv
// CRT/VGA raster sequencer for the Pong display.
// Horizontal and vertical scan FSMs step once per rising level change of the
// divided PixelClock. PixelClock is sampled in the Clock domain and is never
// used as a clock.
// Ports:
//   Clock  - system clock; the only clock
//   Reset  - synchronous, active-high
//   Crt    - crt_timing_if.master:
//            PixelClock in; HSync, VSync, VideoOn, PixelX, PixelY,
//            LineStart, FrameStart out (all registered)
module crt_timing_controller #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FRONT  = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BACK   = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FRONT  = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BACK   = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic         Clock,
  input  logic         Reset,
  crt_timing_if.master Crt
);

  localparam int HTOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int VTOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Last position covered by each region.
  localparam logic [9:0] H_ACT_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_FP_LAST  = 10'(H_ACTIVE + H_FRONT - 1);
  localparam logic [9:0] H_SYN_LAST = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] H_BP_LAST  = 10'(HTOTAL - 1);
  localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_FP_LAST  = 10'(V_ACTIVE + V_FRONT - 1);
  localparam logic [9:0] V_SYN_LAST = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] V_BP_LAST  = 10'(VTOTAL - 1);

  typedef enum logic [1:0] {H_ACT, H_FP, H_SYN, H_BP} hState_t;
  typedef enum logic [1:0] {V_ACT, V_FP, V_SYN, V_BP} vState_t;

  hState_t    hState, hNext;
  vState_t    vState, vNext;
  logic [9:0] x, xNext;
  logic [9:0] y, yNext;
  logic       prevPc;
  logic       tick;
  logic       hWrap, vWrap;

  assign tick = Crt.PixelClock & ~prevPc;

  always_comb begin
    hNext = hState;
    vNext = vState;
    xNext = x;
    yNext = y;
    hWrap = 1'b0;
    vWrap = 1'b0;
    if (tick) begin
      unique case (hState)
        H_ACT: if (x == H_ACT_LAST) hNext = H_FP;
        H_FP:  if (x == H_FP_LAST)  hNext = H_SYN;
        H_SYN: if (x == H_SYN_LAST) hNext = H_BP;
        H_BP:  if (x == H_BP_LAST) begin
                 hNext = H_ACT;
                 hWrap = 1'b1;
               end
      endcase
      xNext = hWrap ? 10'd0 : x + 10'd1;
      // Vertical scan only moves on the tick that ends a line.
      if (hWrap) begin
        unique case (vState)
          V_ACT: if (y == V_ACT_LAST) vNext = V_FP;
          V_FP:  if (y == V_FP_LAST)  vNext = V_SYN;
          V_SYN: if (y == V_SYN_LAST) vNext = V_BP;
          V_BP:  if (y == V_BP_LAST) begin
                   vNext = V_ACT;
                   vWrap = 1'b1;
                 end
        endcase
        yNext = vWrap ? 10'd0 : y + 10'd1;
      end
    end
  end

  // Outputs decode the next state so they describe the position entered on
  // this edge. prevPc resets high so a divider parked high gives no tick.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      prevPc         <= 1'b1;
      hState         <= H_BP;
      vState         <= V_BP;
      x              <= H_BP_LAST;
      y              <= V_BP_LAST;
      Crt.HSync      <= ~SYNC_POL;
      Crt.VSync      <= ~SYNC_POL;
      Crt.VideoOn    <= 1'b0;
      Crt.LineStart  <= 1'b0;
      Crt.FrameStart <= 1'b0;
    end else begin
      prevPc         <= Crt.PixelClock;
      hState         <= hNext;
      vState         <= vNext;
      x              <= xNext;
      y              <= yNext;
      Crt.HSync      <= (hNext == H_SYN) ? SYNC_POL : ~SYNC_POL;
      Crt.VSync      <= (vNext == V_SYN) ? SYNC_POL : ~SYNC_POL;
      Crt.VideoOn    <= (hNext == H_ACT) && (vNext == V_ACT);
      Crt.LineStart  <= hWrap;
      Crt.FrameStart <= hWrap & vWrap;
    end
  end

  assign Crt.PixelX = x;
  assign Crt.PixelY = y;

endmodule

// File: tb/tb_crt_timing_controller.sv
// Directed bench: a default-timing instance for line-level checks and a tiny
// instance (8x7 raster, active-high sync) for whole-frame checks.
module tb_crt_timing_controller;
  logic Clock;
  logic Reset;
  int   vectors;
  int   miscompares;
  int   cycles;

  crt_timing_if bigIf();
  crt_timing_if smlIf();

  crt_timing_controller uBig (
    .Clock (Clock),
    .Reset (Reset),
    .Crt   (bigIf)
  );

  crt_timing_controller #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .SYNC_POL(1'b1)
  ) uSml (
    .Clock (Clock),
    .Reset (Reset),
    .Crt   (smlIf)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial cycles = 0;
  always @(posedge Clock) cycles <= cycles + 1;

  function automatic logic [24:0] pk(int px, int py, bit h, bit v, bit vo, bit ls, bit fs);
    return {10'(px), 10'(py), h, v, vo, ls, fs};
  endfunction

  function automatic logic [24:0] snapB();
    return {bigIf.PixelX, bigIf.PixelY, bigIf.HSync, bigIf.VSync,
            bigIf.VideoOn, bigIf.LineStart, bigIf.FrameStart};
  endfunction

  function automatic logic [24:0] snapS();
    return {smlIf.PixelX, smlIf.PixelY, smlIf.HSync, smlIf.VSync,
            smlIf.VideoOn, smlIf.LineStart, smlIf.FrameStart};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge Clock);
  endtask

  // One PixelClock low/high pair; outputs describe the new position after it.
  task automatic tickB(input int n);
    repeat (n) begin
      bigIf.PixelClock = 1'b0;
      cyc();
      bigIf.PixelClock = 1'b1;
      cyc();
    end
  endtask

  initial begin
    int ex, ey, lastFs, vsCnt;
    bit eh, ev, evo;
    vectors     = 0;
    miscompares = 0;
    Reset = 1'b1;
    bigIf.PixelClock = 1'b1;
    smlIf.PixelClock = 1'b1;
    repeat (3) cyc();
    chk("reset", 32'(snapB()), 32'(pk(799, 524, 1, 1, 0, 0, 0)));
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("pcHeldHigh", 32'(snapB()), 32'(pk(799, 524, 1, 1, 0, 0, 0)));
    end

    tickB(1);
    chk("firstTick", 32'(snapB()), 32'(pk(0, 0, 1, 1, 1, 1, 1)));
    cyc();
    chk("strobeOneClk", 32'(snapB()), 32'(pk(0, 0, 1, 1, 1, 0, 0)));

    tickB(639);
    chk("x639", 32'(snapB()), 32'(pk(639, 0, 1, 1, 1, 0, 0)));
    tickB(1);
    chk("x640", 32'(snapB()), 32'(pk(640, 0, 1, 1, 0, 0, 0)));
    tickB(15);
    chk("x655", 32'(snapB()), 32'(pk(655, 0, 1, 1, 0, 0, 0)));
    tickB(1);
    chk("x656", 32'(snapB()), 32'(pk(656, 0, 0, 1, 0, 0, 0)));
    tickB(95);
    chk("x751", 32'(snapB()), 32'(pk(751, 0, 0, 1, 0, 0, 0)));
    tickB(1);
    chk("x752", 32'(snapB()), 32'(pk(752, 0, 1, 1, 0, 0, 0)));
    tickB(47);
    chk("x799", 32'(snapB()), 32'(pk(799, 0, 1, 1, 0, 0, 0)));
    tickB(1);
    chk("lineWrap", 32'(snapB()), 32'(pk(0, 1, 1, 1, 1, 1, 0)));
    cyc();
    chk("lineStrobeClr", 32'(snapB()), 32'(pk(0, 1, 1, 1, 1, 0, 0)));

    tickB(300);
    chk("x300", 32'(snapB()), 32'(pk(300, 1, 1, 1, 1, 0, 0)));
    bigIf.PixelClock = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      chk("stallLow", 32'(snapB()), 32'(pk(300, 1, 1, 1, 1, 0, 0)));
    end
    bigIf.PixelClock = 1'b1;
    cyc();
    chk("resume", 32'(snapB()), 32'(pk(301, 1, 1, 1, 1, 0, 0)));

    // Reset on the same edge as a tick: reset wins, no advance.
    bigIf.PixelClock = 1'b0;
    cyc();
    bigIf.PixelClock = 1'b1;
    Reset = 1'b1;
    cyc();
    chk("resetOnTick", 32'(snapB()), 32'(pk(799, 524, 1, 1, 0, 0, 0)));
    Reset = 1'b0;
    cyc();
    chk("postResetHold", 32'(snapB()), 32'(pk(799, 524, 1, 1, 0, 0, 0)));
    tickB(1);
    chk("restartFrame", 32'(snapB()), 32'(pk(0, 0, 1, 1, 1, 1, 1)));

    // Small raster: 8 x 7, sync active high, one tick per 4 Clocks.
    chk("sReset", 32'(snapS()), 32'(pk(7, 6, 0, 0, 0, 0, 0)));
    ex = 7; ey = 6; lastFs = -1; vsCnt = 0;
    for (int t = 0; t < 113; t++) begin
      smlIf.PixelClock = 1'b0;
      cyc();
      cyc();
      smlIf.PixelClock = 1'b1;
      cyc();
      if (ex == 7) begin
        ex = 0;
        ey = (ey == 6) ? 0 : ey + 1;
      end else begin
        ex = ex + 1;
      end
      eh  = (ex >= 5) && (ex <= 6);
      ev  = (ey >= 4) && (ey <= 5);
      evo = (ex < 4) && (ey < 3);
      chk("sTick", 32'(snapS()), 32'(pk(ex, ey, eh, ev, evo, ex == 0, (ex == 0) && (ey == 0))));
      if (smlIf.VSync) vsCnt++;
      if (smlIf.FrameStart) begin
        if (lastFs >= 0) chk("sFramePeriod", 32'(cycles - lastFs), 32'd224);
        lastFs = cycles;
      end
      cyc();
      chk("sStrobeClr", {30'd0, smlIf.LineStart, smlIf.FrameStart}, 32'd0);
    end
    chk("sVsyncTicks", 32'(vsCnt), 32'd32);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/crt_timing_controller.md
# crt_timing_controller

Sequences the CRT/VGA raster for the Pong display. It consumes the divided PixelClock produced by the CRT clock divider and runs horizontal and vertical scan state machines. From these it generates HSync, VSync, a visible-region flag, the current pixel coordinates, and line/frame start strobes for the object-drawing logic. Everything runs on the single system Clock; PixelClock is treated as a sampled level, never as a clock.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted sync level (0 = active-low)
- Constraints: each axis total is at most 1024; SYNC, FRONT and BACK are each at least 1.

Ports:
- Clock, input, 1, system clock (100 MHz); the only clock
- Reset, input, 1, synchronous, active-high
- PixelClock, input, 1, divided pixel-rate level from the clock divider; registered in the Clock domain
- HSync, output, 1, horizontal sync, registered
- VSync, output, 1, vertical sync, registered
- VideoOn, output, 1, high while the current pixel is visible, registered
- PixelX, output, 10, current horizontal position, 0..HTOTAL-1
- PixelY, output, 10, current vertical position, 0..VTOTAL-1
- LineStart, output, 1, one-Clock pulse when PixelX enters 0
- FrameStart, output, 1, one-Clock pulse when (PixelX,PixelY) enters (0,0)

## Operation
- Axis totals: HTOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800 by default); VTOTAL is defined the same way (525 by default).
- Tick detection: prev_pc <= PixelClock every Clock. tick = PixelClock & ~prev_pc, so there is exactly one tick per PixelClock rising level change.
- Horizontal FSM states: H_ACT, H_FP, H_SYN, H_BP, advanced only on tick.
  - H_ACT covers X 0..H_ACTIVE-1.
  - H_FP covers the next H_FRONT positions.
  - H_SYN covers the next H_SYNC positions.
  - H_BP covers the next H_BACK positions.
  - H_BP at X=HTOTAL-1 wraps to H_ACT with X=0.
- Vertical FSM states: V_ACT, V_FP, V_SYN, V_BP, with the same structure over PixelY. It advances only on a tick where X wraps from HTOTAL-1 to 0.
- Y wraps from VTOTAL-1 to 0 on the same tick where X wraps.
- Output decode, registered on the same edge the counters update, so outputs always describe the new position:
  - VideoOn = (H state is H_ACT) & (V state is V_ACT).
  - HSync = SYNC_POL while in H_SYN, otherwise ~SYNC_POL. VSync uses V_SYN the same way.
  - LineStart = 1 for exactly the one Clock cycle in which X becomes 0, otherwise 0.
  - FrameStart = 1 for exactly the one Clock cycle in which X and Y both become 0, otherwise 0.
- State, counters and outputs hold on every Clock without a tick.
- Default sync windows: HSync is asserted for X 656..751. VSync is asserted for Y 490..491.

## Timing
- Reset values, applied on the first Clock edge with Reset=1:
  - X = HTOTAL-1 (799), Y = VTOTAL-1 (524); H state H_BP, V state V_BP.
  - HSync = VSync = ~SYNC_POL (1); VideoOn = 0; LineStart = FrameStart = 0.
  - prev_pc = 1.
- Reset has priority over a tick. No tick is taken in a cycle where Reset=1.
- Setting prev_pc = 1 means PixelClock held high through reset (the divider's reset state) produces no tick. The first tick requires PixelClock to be seen low, then high.
- The first tick after reset enters (0,0): VideoOn=1, LineStart=1, FrameStart=1.
- Latency: outputs update on the Clock edge at which PixelClock is first sampled 1 after being sampled 0. This is one edge after PixelClock rises in the register feeding this block.
- At a 100 MHz Clock with a 25 MHz PixelClock, there is one tick every 4 Clocks. LineStart and FrameStart are 1 Clock wide, not 1 pixel wide.
- Reset mid-frame returns the block to the reset values on the next edge. Scanning resumes with (0,0) on the first subsequent tick.
- A PixelClock stuck high or low produces no ticks, and every output holds its value.

## Test plan
- Hold Reset=1 and PixelClock=1 for 3 Clocks, then release with PixelClock still 1 for 10 Clocks -> X=799, Y=524, HSync=1, VSync=1, VideoOn=0, both strobes 0 throughout.
- Drive PixelClock 0 then 1 -> on the next edge X=0, Y=0, VideoOn=1, LineStart=1 and FrameStart=1 for exactly one Clock.
- Run ticks along line 0:
  - X=639: VideoOn=1.
  - X=640: VideoOn=0.
  - X=656: HSync=0.
  - X=752: HSync=1.
  - X=799 then next tick: X=0, Y=1, LineStart pulses, FrameStart stays 0.
- Run a full frame with a clock divider at SystemClockFreq=100, CRTClockFreq=25:
  - VSync=0 exactly for Y 490..491 (1600 ticks).
  - VideoOn=0 for all Y at least 480.
  - Consecutive FrameStart pulses are 420000 ticks (1680000 Clocks) apart.
- Stall PixelClock low for 50 Clocks mid-line at X=300 -> X holds at 300 and all outputs are stable. Resume -> X=301 on the first rising edge.
- Assert Reset for 1 Clock at X=300, Y=200 coincident with a tick -> next state is the reset values (no advance). The next tick gives (0,0) with FrameStart=1.
